// File: rtl/mealy_pkg.sv
// Shared helpers for the Mealy serial-pattern detector: state-width rule,
// update-priority encoding and the elaboration-time next-state functions.
package mealy_pkg;

  localparam int unsigned MIN_LEN = 2;
  localparam int unsigned MAX_LEN = 32;

  typedef logic [MAX_LEN-1:0] pat_t;

  // What the state register does on the coming edge (reset handled separately)
  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_LOAD,
    UPD_ADV
  } upd_e;

  // Width of the matched-prefix register
  function automatic int unsigned state_width(input int unsigned len);
    return $clog2(len);
  endfunction

  // Bit j of the pattern counted in arrival order (j=0 is received first)
  function automatic logic pat_bit(input pat_t pattern, input int unsigned len,
                                   input int unsigned j);
    pat_t s;
    s = pattern >> (len - 1 - j);
    return s[0];
  endfunction

  // Longest proper prefix of the first n pattern bits that is also their suffix
  function automatic int unsigned border(input pat_t pattern, input int unsigned len,
                                         input int unsigned n);
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned b = 1; b < n; b++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < b; j++)
        if (pat_bit(pattern, len, j) != pat_bit(pattern, len, n - b + j)) ok = 1'b0;
      if (ok) best = b;
    end
    return best;
  endfunction

  // Next matched-prefix length from state k on input bit b
  function automatic int unsigned next_state(input pat_t pattern, input int unsigned len,
                                             input int unsigned k, input logic b,
                                             input logic overlap);
    int unsigned best;
    int unsigned idx;
    logic        ok;
    logic        sbit;
    if (b == pat_bit(pattern, len, k)) begin
      if (k + 1 < len) return k + 1;
      return overlap ? border(pattern, len, len) : 0;
    end
    // Mismatch: longest pattern prefix that ends the string (k matched bits ++ b)
    best = 0;
    for (int unsigned n = 1; n <= k; n++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < n; j++) begin
        idx  = k + 1 - n + j;
        sbit = (idx < k) ? pat_bit(pattern, len, idx) : b;
        if (pat_bit(pattern, len, j) != sbit) ok = 1'b0;
      end
      if (ok) best = n;
    end
    return best;
  endfunction

endpackage

// File: rtl/mealy_seq_detector_cnt.sv
// Saturating event counter with synchronous reset and clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] CNT
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear beats increment; increment stops at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (INC && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial-pattern detector with preload, enable and a
// saturating hit counter. The transition table is fully elaborated.
module mealy_seq_detector
  import mealy_pkg::*;
#(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter logic               OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8,
  localparam int unsigned       SW      = state_width(PAT_LEN)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             I,
  input  logic             LOAD,
  input  logic [SW-1:0]    LOAD_Q,
  input  logic             CLR_CNT,
  output logic [SW-1:0]    Q,
  output logic             Y,
  output logic [CNT_W-1:0] HIT_CNT
);

  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] nxt_tbl [2*PAT_LEN];
  logic [SW:0]   tbl_idx;
  logic          load_ok;
  upd_e          upd;

  // Table entry {k, bit} holds the state reached from prefix length k on that bit
  for (genvar k = 0; k < PAT_LEN; k++) begin : g_tbl
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam logic [SW-1:0] NXT =
        SW'(next_state(pat_t'(PATTERN), PAT_LEN, k, (b == 1), OVERLAP));
      assign nxt_tbl[2*k+b] = NXT;
    end
  end

  assign load_ok = (32'(LOAD_Q) < PAT_LEN);
  assign tbl_idx = {state_q, I};

  // Select update source (LOAD over EN over hold) and form next state
  always_comb begin
    upd     = UPD_HOLD;
    state_d = state_q;
    if (LOAD)    upd = UPD_LOAD;
    else if (EN) upd = UPD_ADV;
    case (upd)
      UPD_LOAD: state_d = load_ok ? LOAD_Q : '0;
      UPD_ADV:  state_d = nxt_tbl[tbl_idx];
      default:  state_d = state_q;
    endcase
  end

  // Matched-prefix register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= '0;
    else     state_q <= state_d;
  end

  assign Q = state_q;
  assign Y = ~RST & ~LOAD & EN & (state_q == SW'(PAT_LEN - 1)) & (I == PATTERN[0]);

  sat_counter #(
    .W(CNT_W)
  ) u_hit_cnt (
    .CLK(CLK),
    .RST(RST),
    .CLR(CLR_CNT),
    .INC(Y),
    .CNT(HIT_CNT)
  );

endmodule
